// File: rtl/frame_de_decoder_pkg.sv
// Shared widths, state encodings and helpers for the data-enable frame decoder.
package frame_de_decoder_pkg;

  localparam int PIX_W = 4;
  localparam int GAP_W = 8;

  localparam logic [1:0] ST_SEARCH   = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_ACTIVE   = 2'd2;
  localparam logic [1:0] ST_GAP      = 2'd3;

  typedef enum logic [1:0] {
    SEARCH   = ST_SEARCH,
    WAIT_SOF = ST_WAIT_SOF,
    ACTIVE   = ST_ACTIVE,
    GAP      = ST_GAP
  } state_t;

  function automatic logic [PIX_W-1:0] sat_inc_pix(input logic [PIX_W-1:0] v);
    return (&v) ? v : v + PIX_W'(1);
  endfunction

endpackage

// File: rtl/frame_de_decoder_sat_counter.sv
// Saturating up-counter; clr together with inc restarts the count at 1.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= {{(W-1){1'b0}}, inc};
    else if (inc && !(&q))
      q <= q + W'(1);
  end

endmodule

// File: rtl/frame_de_decoder.sv
// Recovers line/frame structure from a data-enable strobe, emits pixel
// coordinates and markers, and checks line length and lines per frame.
module frame_de_decoder
  import frame_de_decoder_pkg::*;
#(
  parameter int H_ACTIVE  = 5,
  parameter int V_ACTIVE  = 10,
  parameter int GAP_FRAME = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             de,
  output logic             pix_valid,
  output logic [PIX_W-1:0] x,
  output logic [PIX_W-1:0] y,
  output logic             sol,
  output logic             sof,
  output logic             eof,
  output logic             h_err,
  output logic             v_err,
  output logic [PIX_W-1:0] lines_seen,
  output logic             locked
);

  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_FRAME);
  localparam logic [PIX_W-1:0] H_EXP   = PIX_W'(H_ACTIVE);
  localparam logic [PIX_W-1:0] V_EXP   = PIX_W'(V_ACTIVE);

  state_t             state;
  logic [GAP_W-1:0]   gap_cnt, gap_next;
  logic [PIX_W-1:0]   run_len, line_cnt;
  logic               h_seen;
  logic               start_frame, start_line, run_end, frame_end, h_bad, v_bad;

  always_comb begin
    gap_next    = (&gap_cnt) ? gap_cnt : gap_cnt + GAP_W'(1);
    start_frame = (state == WAIT_SOF) && de;
    start_line  = (state == GAP) && de;
    run_end     = (state == ACTIVE) && !de;
    // A gap that already qualifies on the falling sample still ends the frame.
    frame_end   = !de && ((state == ACTIVE) || (state == GAP)) && (gap_next >= GAP_LIM);
    h_bad       = run_end && (run_len != H_EXP);
    v_bad       = frame_end && (line_cnt != V_EXP);
  end

  sat_counter #(.W(GAP_W)) u_gap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!en || de),
    .inc (en && !de),
    .q   (gap_cnt)
  );

  sat_counter #(.W(PIX_W)) u_run_len (
    .clk (clk),
    .rst (rst),
    .clr (!en || start_frame || start_line),
    .inc (en && de && (start_frame || start_line || (state == ACTIVE))),
    .q   (run_len)
  );

  sat_counter #(.W(PIX_W)) u_line_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!en || start_frame),
    .inc (en && (start_frame || start_line)),
    .q   (line_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state      <= SEARCH;
      pix_valid  <= 1'b0;
      x          <= '0;
      y          <= '0;
      sol        <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      h_err      <= 1'b0;
      v_err      <= 1'b0;
      lines_seen <= '0;
      locked     <= 1'b0;
      h_seen     <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      sol       <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      h_err     <= 1'b0;
      v_err     <= 1'b0;
      unique case (state)
        SEARCH: begin
          if (!de && (gap_next >= GAP_LIM)) state <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (de) begin
            state     <= ACTIVE;
            sof       <= 1'b1;
            sol       <= 1'b1;
            pix_valid <= 1'b1;
            x         <= '0;
            y         <= '0;
            h_seen    <= 1'b0;
          end
        end
        ACTIVE: begin
          if (de) begin
            pix_valid <= 1'b1;
            x         <= sat_inc_pix(x);
          end else begin
            state <= GAP;
            h_err <= h_bad;
            if (h_bad) begin
              locked <= 1'b0;
              h_seen <= 1'b1;
            end
          end
        end
        GAP: begin
          if (de) begin
            state     <= ACTIVE;
            sol       <= 1'b1;
            pix_valid <= 1'b1;
            x         <= '0;
            y         <= sat_inc_pix(y);
          end
        end
        default: state <= SEARCH;
      endcase
      if (frame_end) begin
        state      <= WAIT_SOF;
        eof        <= 1'b1;
        v_err      <= v_bad;
        lines_seen <= line_cnt;
        locked     <= !v_bad && !h_seen && !h_bad;
      end
    end
  end

endmodule

// File: tb/tb_frame_de_decoder.sv
// Randomised and directed bench for frame_de_decoder against a sample-level model.
module tb_frame_de_decoder;

  localparam int H_ACTIVE  = 5;
  localparam int V_ACTIVE  = 10;
  localparam int GAP_FRAME = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       de  = 1'b0;
  logic       pix_valid, sol, sof, eof, h_err, v_err, locked;
  logic [3:0] x, y, lines_seen;

  int compared   = 0;
  int mismatched = 0;

  frame_de_decoder #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .GAP_FRAME(GAP_FRAME)) dut (
    .clk(clk), .rst(rst), .en(en), .de(de),
    .pix_valid(pix_valid), .x(x), .y(y), .sol(sol), .sof(sof), .eof(eof),
    .h_err(h_err), .v_err(v_err), .lines_seen(lines_seen), .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference model: counts raw low/high samples and derives the markers.
  int   m_gap, m_run, m_lines, m_x, m_y, m_lines_seen;
  bit   m_synced, m_in_frame, m_prev_hi, m_hseen, m_locked;
  bit   e_pix, e_sol, e_sof, e_eof, e_herr, e_verr;
  logic [18:0] exp_vec;
  bit   stim[$];

  function automatic int min15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic logic [18:0] obs_vec();
    return {pix_valid, x, y, sol, sof, eof, h_err, v_err, lines_seen, locked};
  endfunction

  task automatic model_step(input bit r, input bit e, input bit d);
    {e_pix, e_sol, e_sof, e_eof, e_herr, e_verr} = '0;
    if (r || !e) begin
      m_gap = 0; m_run = 0; m_lines = 0; m_x = 0; m_y = 0; m_lines_seen = 0;
      m_synced = 0; m_in_frame = 0; m_prev_hi = 0; m_hseen = 0; m_locked = 0;
    end else begin
      if (d) begin
        if (m_in_frame && m_prev_hi) begin
          e_pix = 1; m_x = min15(m_x + 1); m_run++;
        end else if (m_in_frame) begin
          e_sol = 1; e_pix = 1; m_x = 0; m_y = min15(m_y + 1); m_lines++; m_run = 1;
        end else if (m_synced) begin
          e_sof = 1; e_sol = 1; e_pix = 1; m_x = 0; m_y = 0; m_lines = 1; m_run = 1;
          m_hseen = 0; m_in_frame = 1;
        end
        m_gap = 0;
      end else begin
        m_gap++;
        if (m_in_frame && m_prev_hi && m_run != H_ACTIVE) begin
          e_herr = 1; m_locked = 0; m_hseen = 1;
        end
        if (m_gap >= GAP_FRAME) begin
          if (m_in_frame) begin
            e_eof = 1;
            m_lines_seen = min15(m_lines);
            e_verr = (m_lines != V_ACTIVE);
            m_locked = !e_verr && !m_hseen;
            m_in_frame = 0;
          end
          m_synced = 1;
        end
      end
      m_prev_hi = d;
    end
    exp_vec = {e_pix, 4'(m_x), 4'(m_y), e_sol, e_sof, e_eof, e_herr, e_verr,
               4'(m_lines_seen), m_locked};
  endtask

  task automatic step(input bit r, input bit e, input bit d);
    rst = r; en = e; de = d;
    @(posedge clk);
    #1;
    model_step(r, e, d);
  endtask

  task automatic add_lows(input int n);
    for (int i = 0; i < n; i++) stim.push_back(1'b0);
  endtask

  task automatic add_highs(input int n);
    for (int i = 0; i < n; i++) stim.push_back(1'b1);
  endtask

  // Generator-shaped frame: 16 line slots of 9 cycles, first n_lines active.
  task automatic add_frame(input int n_lines, input int bad_line, input int bad_len);
    for (int l = 0; l < 16; l++) begin
      if (l < n_lines) begin
        add_lows(2);
        add_highs((l == bad_line) ? bad_len : H_ACTIVE);
        add_lows(2);
      end else begin
        add_lows(9);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1'($urandom));
      compared++;
      if (obs_vec() !== 19'd0) begin
        mismatched++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=%h", i, obs_vec(), 19'd0);
      end
    end
    step(0, 1, 0);
    compared++;
    if (obs_vec() !== exp_vec) begin
      mismatched++;
      $display("FAIL reset_release got=%h want=%h", obs_vec(), exp_vec);
    end
  endtask

  task automatic test_clean_frames();
    int n_sof = 0, n_sol = 0, n_pix = 0, n_eof = 0, n_range = 0, n_unlocked_eof = 0;
    stim.delete();
    add_lows(20);
    add_frame(V_ACTIVE, -1, H_ACTIVE);
    add_frame(V_ACTIVE, -1, H_ACTIVE);
    foreach (stim[i]) begin
      step(0, 1, stim[i]);
      compared++;
      if (obs_vec() !== exp_vec) begin
        mismatched++;
        $display("FAIL clean_cycle i=%0d got=%h want=%h", i, obs_vec(), exp_vec);
      end
      n_sof += int'(sof); n_sol += int'(sol); n_pix += int'(pix_valid); n_eof += int'(eof);
      if (pix_valid && (x > 4 || y > 9)) n_range++;
      if (eof && (!locked || v_err || lines_seen != 4'd10)) n_unlocked_eof++;
    end
    compared++;
    if ({n_sof, n_sol, n_pix, n_eof} !== {32'd2, 32'd20, 32'd100, 32'd2}) begin
      mismatched++;
      $display("FAIL clean_counts got sof=%0d sol=%0d pix=%0d eof=%0d want 2/20/100/2",
               n_sof, n_sol, n_pix, n_eof);
    end
    compared++;
    if (n_range != 0 || n_unlocked_eof != 0) begin
      mismatched++;
      $display("FAIL clean_coords got range_bad=%0d eof_bad=%0d want 0/0", n_range, n_unlocked_eof);
    end
  endtask

  task automatic test_h_err();
    int n_herr = 0, n_lock_after = 0;
    stim.delete();
    add_frame(V_ACTIVE, 3, 4);
    add_frame(V_ACTIVE, -1, H_ACTIVE);
    foreach (stim[i]) begin
      step(0, 1, stim[i]);
      compared++;
      if (obs_vec() !== exp_vec) begin
        mismatched++;
        $display("FAIL herr_cycle i=%0d got=%h want=%h", i, obs_vec(), exp_vec);
      end
      if (h_err) begin
        n_herr++;
        if (locked || stim[i] != 1'b0 || stim[i-1] != 1'b1) n_lock_after++;
      end
    end
    compared++;
    if (n_herr != 1 || n_lock_after != 0 || locked !== 1'b1) begin
      mismatched++;
      $display("FAIL herr_summary got herr=%0d bad=%0d locked=%b want 1/0/1",
               n_herr, n_lock_after, locked);
    end
  endtask

  task automatic test_v_err();
    int n_verr = 0;
    logic [3:0] seen = '0;
    stim.delete();
    add_frame(9, -1, H_ACTIVE);
    foreach (stim[i]) begin
      step(0, 1, stim[i]);
      compared++;
      if (obs_vec() !== exp_vec) begin
        mismatched++;
        $display("FAIL verr_cycle i=%0d got=%h want=%h", i, obs_vec(), exp_vec);
      end
      if (eof && v_err) begin n_verr++; seen = lines_seen; end
    end
    compared++;
    if (n_verr != 1 || seen !== 4'd9 || locked !== 1'b0) begin
      mismatched++;
      $display("FAIL verr_summary got verr=%0d lines=%0d locked=%b want 1/9/0", n_verr, seen, locked);
    end
  endtask

  task automatic test_gap_boundary();
    int n_sol = 0, eof_at = -1, y2 = -1;
    stim.delete();
    add_highs(5); add_lows(15); add_highs(5); add_lows(16);
    foreach (stim[i]) begin
      step(0, 1, stim[i]);
      compared++;
      if (obs_vec() !== exp_vec) begin
        mismatched++;
        $display("FAIL gap_cycle i=%0d got=%h want=%h", i, obs_vec(), exp_vec);
      end
      if (sol) begin n_sol++; if (n_sol == 2) y2 = int'(y); end
      if (eof && eof_at < 0) eof_at = i;
    end
    compared++;
    if (n_sol != 2 || y2 != 1 || eof_at != 40) begin
      mismatched++;
      $display("FAIL gap_boundary got sol=%0d y=%0d eof_at=%0d want 2/1/40", n_sol, y2, eof_at);
    end
  endtask

  task automatic test_abort_midline(input bit use_rst, input string name);
    int n_pix = 0, n_sof = 0;
    step(0, 1, 0); step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    compared++;
    if ({pix_valid, x} !== {1'b1, 4'd2}) begin
      mismatched++;
      $display("FAIL %s_pre got pix=%b x=%0d want 1/2", name, pix_valid, x);
    end
    if (use_rst) step(1, 1, 1); else step(0, 0, 1);
    compared++;
    if (obs_vec() !== 19'd0 || exp_vec !== 19'd0) begin
      mismatched++;
      $display("FAIL %s_clear got=%h want=%h", name, obs_vec(), 19'd0);
    end
    stim.delete();
    add_highs(3); add_lows(10); add_highs(3); add_lows(16); add_highs(2);
    foreach (stim[i]) begin
      step(0, 1, stim[i]);
      compared++;
      if (obs_vec() !== exp_vec) begin
        mismatched++;
        $display("FAIL %s_cycle i=%0d got=%h want=%h", name, i, obs_vec(), exp_vec);
      end
      if (i < 32) n_pix += int'(pix_valid);
      n_sof += int'(sof);
    end
    compared++;
    if (n_pix != 0 || n_sof != 1) begin
      mismatched++;
      $display("FAIL %s_resync got early_pix=%0d sof=%0d want 0/1", name, n_pix, n_sof);
    end
  endtask

  task automatic test_random();
    int cyc = 0;
    bit r, e;
    while (cyc < 3000) begin
      int hi, lo, pick;
      pick = int'($urandom_range(0, 19));
      hi = (pick < 14) ? H_ACTIVE : (pick < 18) ? int'($urandom_range(1, 8)) : int'($urandom_range(15, 18));
      pick = int'($urandom_range(0, 19));
      lo = (pick < 12) ? 4 : (pick < 17) ? int'($urandom_range(13, 18)) : int'($urandom_range(30, 60));
      for (int i = 0; i < hi + lo; i++) begin
        pick = int'($urandom_range(0, 199));
        r = (pick == 0);
        e = (pick != 1);
        step(r, e, i < hi);
        cyc++;
        compared++;
        if (obs_vec() !== exp_vec) begin
          mismatched++;
          $display("FAIL random_cycle c=%0d got=%h want=%h", cyc, obs_vec(), exp_vec);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frames();
    test_h_err();
    test_v_err();
    test_gap_boundary();
    test_abort_midline(1'b0, "en_drop");
    test_abort_midline(1'b1, "rst_pulse");
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/frame_de_decoder.md
# frame_de_decoder

Receive-side counterpart of the LCD frame/timing generator. It samples the single-bit data-enable (`de`) strobe that the generator drives, recovers the frame and line boundaries, and produces per-pixel coordinates with start-of-line and start-of-frame markers. It also checks each line's active length and each frame's active-line count against expected values, and flags mismatches. It sits between the panel-timing source and downstream pixel consumers, or acts as a bench-side monitor.

## Interface
- `H_ACTIVE`, 5: expected `de`-high cycles per line.
- `V_ACTIVE`, 10: expected active lines per frame.
- `GAP_FRAME`, 16: a `de`-low run of this many cycles or more marks a frame boundary. Must be in 1..255.
- `clk`  in  1: single clock; everything is on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `en`  in  1: enable. When low, the block behaves as reset.
- `de`  in  1: data-enable strobe from the timing generator.
- `pix_valid`  out  1: the pixel sampled on the previous edge was active.
- `x`  out  4: pixel index within the line, 0-based, saturates at 15.
- `y`  out  4: line index within the frame, 0-based, saturates at 15.
- `sol`  out  1: start-of-line pulse, coincident with `x==0`.
- `sof`  out  1: start-of-frame pulse, coincident with `x==0`, `y==0`.
- `eof`  out  1: end-of-frame pulse, issued when the frame gap qualifies.
- `h_err`  out  1: one-cycle pulse when a line's active run length differs from `H_ACTIVE`.
- `v_err`  out  1: one-cycle pulse with `eof` when the frame's line count differs from `V_ACTIVE`.
- `lines_seen`  out  4: line count of the last completed frame, updated at `eof`.
- `locked`  out  1: high after a frame completes with no `h_err` and no `v_err`.

## Operation
- Internal counters:
  - `gap_cnt`, 8 bits: consecutive `de`=0 samples, saturates at 255, cleared on a `de`=1 sample.
  - `run_len`, 4 bits: current active run length, saturating.
  - `line_cnt`, 4 bits: lines in the current frame, saturating.
- States:
  - SEARCH: entered on reset or `en`=0. Counts the gap. No pixel outputs. Goes to WAIT_SOF when `gap_cnt` reaches `GAP_FRAME`.
  - WAIT_SOF: on a `de`=1 sample, go to ACTIVE and emit `sof`+`sol`, with `x`=0, `y`=0 and `line_cnt`=1.
  - ACTIVE: each `de`=1 sample emits `pix_valid` and increments `x`. On a `de`=0 sample, go to GAP. If `run_len`≠`H_ACTIVE`, pulse `h_err`.
  - GAP:
    - On a `de`=1 sample with `gap_cnt` < `GAP_FRAME`: start a new line. Emit `sol`, set `x`=0, increment `y` and `line_cnt` (both saturating), and go to ACTIVE.
    - When `gap_cnt` reaches `GAP_FRAME`: pulse `eof`, latch `lines_seen`=`line_cnt`, and pulse `v_err` if `line_cnt`≠`V_ACTIVE`. Then go to WAIT_SOF.
- `locked`:
  - Set at an `eof` with `v_err`=0 when no `h_err` occurred since the preceding `sof`.
  - Cleared by any `h_err`, any `v_err`, reset, or `en`=0.
- Boundary cases:
  - Active run longer than 15 cycles: `x` holds at 15 and `h_err` fires at the run's end.
  - Gap of exactly `GAP_FRAME`-1: treated as a line gap.
  - Gap of exactly `GAP_FRAME`: treated as a frame boundary.
  - `de` rising on the same edge that `gap_cnt` would reach `GAP_FRAME`: `de` wins, and the edge counts as a new line.

## Timing
- All outputs are registered. Latency is 1 cycle: the `de` sample at edge k is reflected in `pix_valid`/`x`/`y`/`sol`/`sof` after edge k.
- `h_err` appears after the edge that samples the first `de`=0.
- `eof`/`v_err` appear after the edge on which `gap_cnt` becomes `GAP_FRAME`.
- Reset and `en`=0 take effect on the next edge. Outputs are 0 after that edge: `pix_valid`, `sol`, `sof`, `eof`, `h_err`, `v_err`, `locked`, `x`, `y`, `lines_seen`. Counters are 0 and the state is SEARCH.
- After reset or `en`=0, no `pix_valid` is emitted until a full `GAP_FRAME` gap has been seen. The block never locks onto a frame midway.

## Structure
- Shared package holds:
  - State encodings SEARCH/WAIT_SOF/ACTIVE/GAP as 2-bit localparams.
  - Counter widths: 4-bit pixel/line, 8-bit gap.
- The saturating counter is a natural sub-module, `sat_counter`, parameterised on width, with clear and increment inputs. It is used three times.
- The FSM and output registers stay in the top level.

## Test plan
- Reset, then drive the generator pattern: lines of 2 low, 5 high, 2 low; 10 active lines; 6 blank lines. Required per frame: one `sof`, 10 `sol`, 50 `pix_valid` with `x` 0..4 and `y` 0..9, then `eof` with `lines_seen`=10 and `v_err`=0. `locked` rises after the first `eof`.
- Line 3 has a 4-cycle `de` run. Required: `h_err` one cycle after the falling sample, and `locked` drops. The next clean frame re-locks.
- Frame with 9 active lines. Required: `eof` with `v_err`=1 and `lines_seen`=9.
- Gap of 15 between runs gives `sol` with `y`+1 and no `eof`. A gap of 16 gives `eof` after exactly 16 low samples.
- `en` dropped at pixel x=2. Required: all outputs 0 on the next cycle. After `en` returns, there is no `pix_valid` until a ≥16-cycle gap and a rising `de`, which produces `sof`.
- `rst` asserted mid-ACTIVE for 1 cycle. Required: identical behaviour to the `en` case.
